// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: byte-wide ROM port plus the instruction valid/ready handshake to decode.
// The fetch controller is the master; the ROM/decode side is the slave.
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a byte-wide ROM, assembles little-endian 32-bit words,
// hands them to decode over valid/ready, and owns the PC including branch/jump redirect.
module instr_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               misalign_err,
    instr_fetch_ctrl_if.master bus
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       partial_q, partial_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              misalign_q, misalign_d;

    assign bus.rom_addr    = pc_q + ADDR_W'(byte_cnt_q);
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign misalign_err    = misalign_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_cnt_d = byte_cnt_q;
        partial_d  = partial_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = 1'b0;

        // Redirect overrides everything; a coincident handshake in HOLD still completes
        // because decode samples valid/ready in the same cycle, but pc takes the target.
        if (redirect_valid) begin
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            byte_cnt_d = 2'd0;
            partial_d  = '0;
            state_d    = FETCH;
            misalign_d = |redirect_pc[1:0];
        end else begin
            case (state_q)
                FETCH: begin
                    if (fetch_en) begin
                        if (byte_cnt_q == 2'd3) begin
                            instr_d    = {bus.rom_data, partial_q};
                            instr_pc_d = pc_q;
                            byte_cnt_d = 2'd0;
                            state_d    = HOLD;
                        end else begin
                            case (byte_cnt_q)
                                2'd0:    partial_d[7:0]   = bus.rom_data;
                                2'd1:    partial_d[15:8]  = bus.rom_data;
                                default: partial_d[23:16] = bus.rom_data;
                            endcase
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    if (bus.instr_ready) begin
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            byte_cnt_q <= 2'd0;
            partial_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_cnt_q <= byte_cnt_d;
            partial_q  <= partial_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule
